// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field widths, special encodings and the state type
// used by the normalize/round block and its rounding helper.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int MANT_W = SIG_W + 4;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  localparam int              EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN   = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } fp_state_e;

  function automatic logic [WORD_W-1:0] fp_pack(input logic             s,
                                                input logic [EXP_W-1:0]  e,
                                                input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational round-to-nearest-even on a 24-bit significand.
// A carry out of the top bit is reported and the significand is returned
// as 1.000...0 so the caller only has to bump the exponent.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic             guard_i,
  input  logic             round_i,
  input  logic             sticky_i,
  output logic [SIG_W-1:0] sig_o,
  output logic             carry_o
);

  function automatic logic rne_inc(input logic lsb, input logic g,
                                   input logic r, input logic s);
    return g && (r || s || lsb);
  endfunction

  logic [SIG_W:0] sum_w;

  // Add the rounding increment and renormalize on carry-out.
  always_comb begin
    sum_w   = {1'b0, sig_i} + {{SIG_W{1'b0}}, rne_inc(sig_i[0], guard_i, round_i, sticky_i)};
    carry_o = sum_w[SIG_W];
    sig_o   = sum_w[SIG_W] ? {1'b1, {(SIG_W-1){1'b0}}} : sum_w[SIG_W-1:0];
  end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: takes a raw adder result (carry, 24-bit significand, G/R/S),
// normalizes it one bit per cycle, rounds to nearest-even and packs an
// IEEE-754 single. Handshaked on both sides; one operation in flight.
// Optional macro FP_NORM_SUBNORMAL_EN: emit subnormal results instead of
// flushing them to signed zero.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int MAX_NORM_CYC = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_overflow,
  output logic              out_underflow
);

  // Exponent carries one extra bit so overflow past 255 stays visible.
  localparam int EXPI_W = EXP_W + 1;
  localparam int HID    = MANT_W - 2;
  localparam int CNT_W  = $clog2(MAX_NORM_CYC + 1);
  // Largest biased exponent value (all-ones field) marks infinity.
  localparam logic [EXPI_W-1:0] EXP_TOP = EXPI_W'(2 * EXP_BIAS + 1);

  fp_state_e state_q, state_d;

  logic              sign_q, sign_d;
  logic [EXPI_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              in_special;
  logic [MANT_W-1:0] mant_nx;
  logic [EXPI_W-1:0] exp_nx;
  logic              cnt_last;
  logic              norm_exit;

  logic [SIG_W-1:0]  rne_sig;
  logic              rne_carry;
  logic [EXPI_W-1:0] exp_rnd;
  logic [WORD_W-1:0] rnd_sum;
  logic              rnd_ovf;
  logic              rnd_unf;

  assign in_special = in_nan || in_inf || (in_mant == '0);
  assign cnt_last   = (cnt_q == CNT_W'(MAX_NORM_CYC - 1));

  // One normalization step: right shift on carry, else left shift toward the hidden bit.
  always_comb begin
    mant_nx = mant_q;
    exp_nx  = exp_q;
    if (mant_q[MANT_W-1]) begin
      // Shifted-out bit folds into sticky so rounding still sees it.
      mant_nx = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
      exp_nx  = exp_q + EXPI_W'(1);
    end else if (!mant_q[HID] && (exp_q > EXPI_W'(1))) begin
      mant_nx = {mant_q[MANT_W-2:0], 1'b0};
      exp_nx  = exp_q - EXPI_W'(1);
    end
  end

  // Leave NORM in the same cycle the step lands on a normalized or minimum-exponent value.
  assign norm_exit = mant_q[MANT_W-1] || mant_nx[HID] || (exp_nx <= EXPI_W'(1)) || cnt_last;

  fp_rne_round u_rne (
    .sig_i    (mant_q[HID:3]),
    .guard_i  (mant_q[2]),
    .round_i  (mant_q[1]),
    .sticky_i (mant_q[0]),
    .sig_o    (rne_sig),
    .carry_o  (rne_carry)
  );

  assign exp_rnd = exp_q + {{(EXPI_W-1){1'b0}}, rne_carry};

`ifndef FP_NORM_SUBNORMAL_EN
  logic unused_rne_msb;
  assign unused_rne_msb = rne_sig[SIG_W-1];
`endif

  // Pack the rounded value, detecting overflow and the below-normal case.
  always_comb begin
    rnd_sum = '0;
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (!mant_q[HID]) begin
      rnd_unf = 1'b1;
`ifdef FP_NORM_SUBNORMAL_EN
      // A round-up that reaches the hidden bit becomes the smallest normal.
      rnd_sum = fp_pack(sign_q, {{(EXP_W-1){1'b0}}, rne_sig[SIG_W-1]}, rne_sig[FRAC_W-1:0]);
`else
      rnd_sum = fp_pack(sign_q, '0, '0);
`endif
    end else if (exp_rnd >= EXP_TOP) begin
      rnd_ovf = 1'b1;
      rnd_sum = fp_pack(sign_q, EXP_MAX, '0);
    end else begin
      rnd_sum = fp_pack(sign_q, exp_rnd[EXP_W-1:0], rne_sig[FRAC_W-1:0]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; specials skip normalization and go straight to HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = in_special ? HOLD : NORM;
      NORM:    if (norm_exit) state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

  // Datapath next-state: capture, normalize step, round result.
  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {1'b0, in_exp};
          mant_d = in_mant;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (in_nan) begin
            sum_d = QNAN;
          end else if (in_inf) begin
            sum_d = fp_pack(in_sign, EXP_MAX, '0);
          end else if (in_mant == '0) begin
            sum_d = fp_pack(in_sign, '0, '0);
          end
        end
      end
      NORM: begin
        mant_d = mant_nx;
        exp_d  = exp_nx;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      ROUND: begin
        sum_d = rnd_sum;
        ovf_d = rnd_ovf;
        unf_d = rnd_unf;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also discards any captured operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign out_sum       = sum_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: self-checking bench for fp_norm_round with directed
// corner cases and randomized operands against a value-level reference.
module tb_fp_norm_round;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;
  logic        out_underflow;

  int checks;
  int failures;

  fp_norm_round #(.MAX_NORM_CYC(27)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic        nan;
    logic        inf;
    logic [31:0] sum;
    logic        ov;
    logic        uf;
    int          lat;
  } vec_t;

  // Reference: value-level normalize, RNE on the integer significand, IEEE packing.
  task automatic model(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic nan, input logic inf,
                       output logic [31:0] sum, output logic ov, output logic uf,
                       output int lat);
    int          e_i;
    int          shifts;
    int          kept;
    int          rem;
    logic [27:0] mm;
    ov = 1'b0;
    uf = 1'b0;
    lat = 1;
    if (nan) begin
      sum = 32'h7FC00000;
    end else if (inf) begin
      sum = {s, 8'hFF, 23'd0};
    end else if (m == 28'd0) begin
      sum = {s, 31'd0};
    end else begin
      e_i = int'(e);
      mm = m;
      shifts = 0;
      if (mm >= 28'h8000000) begin
        mm = (mm >> 1) | (mm & 28'd1);
        e_i = e_i + 1;
        lat = 3;
      end else begin
        while (mm < 28'h4000000 && e_i > 1) begin
          mm = mm << 1;
          e_i = e_i - 1;
          shifts++;
        end
        lat = 2 + ((shifts > 0) ? shifts : 1);
      end
      kept = int'(mm >> 3);
      rem  = int'(mm % 28'd8);
      if (rem > 4 || (rem == 4 && (kept % 2) == 1)) kept = kept + 1;
      if (kept == (1 << 24)) begin
        kept = 1 << 23;
        e_i = e_i + 1;
      end
      if (mm < 28'h4000000) begin
        uf = 1'b1;
`ifdef FP_NORM_SUBNORMAL_EN
        sum = {s, 31'(kept)};
`else
        sum = {s, 31'd0};
`endif
      end else if (e_i >= 255) begin
        ov = 1'b1;
        sum = {s, 8'hFF, 23'd0};
      end else begin
        sum = {s, 8'(e_i), 23'(kept % (1 << 23))};
      end
    end
  endtask

  // Drive one operation, wait (bounded) for the result, consume it.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic nan, input logic inf,
                       output logic [31:0] sum, output logic ov, output logic uf,
                       output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_sign = s; in_exp = e; in_mant = m; in_nan = nan; in_inf = inf;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    sum = out_sum;
    ov = out_overflow;
    uf = out_underflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic rand_operand(output logic s, output logic [7:0] e, output logic [27:0] m,
                              output logic nan, output logic inf);
    int pos;
    int r;
    logic [27:0] mask;
    s = 1'($urandom);
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd1;
    else if (r == 1) e = 8'd254;
    else if (r == 2) e = 8'($urandom_range(1, 8));
    else             e = 8'($urandom_range(1, 254));
    pos = $urandom_range(0, 27);
    mask = (28'd1 << (pos + 1)) - 28'd1;
    m = (28'($urandom) & mask) | (28'd1 << pos);
    r = $urandom_range(0, 31);
    nan = (r == 0);
    inf = (r == 1) || (r == 2 && $urandom_range(0, 1) == 1);
    if (r == 3) m = 28'd0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin failures++; $display("FAIL reset_out_sum: got %h expected 00000000", out_sum); end
    checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", out_overflow); end
    checks++; if (out_underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %b expected 0", out_underflow); end
  endtask

  task automatic test_directed;
    vec_t        dv[10];
    logic [31:0] sum;
    logic        ov, uf;
    int          lat;
    dv[0] = '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    dv[1] = '{1'b0, 8'd127, 28'h0800000, 1'b0, 1'b0, 32'h3E000000, 1'b0, 1'b0, 5};
    dv[2] = '{1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    dv[3] = '{1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3};
`ifdef FP_NORM_SUBNORMAL_EN
    dv[4] = '{1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0, 32'h00400000, 1'b0, 1'b1, 3};
`else
    dv[4] = '{1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 3};
`endif
    dv[5] = '{1'b1, 8'd10,  28'h4000000, 1'b1, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1};
    dv[6] = '{1'b1, 8'd10,  28'h4000000, 1'b0, 1'b1, 32'hFF800000, 1'b0, 1'b0, 1};
    dv[7] = '{1'b1, 8'd50,  28'h0000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1};
    dv[8] = '{1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3};
    dv[9] = '{1'b1, 8'd127, 28'h4000005, 1'b0, 1'b0, 32'hBF800001, 1'b0, 1'b0, 3};
    for (int i = 0; i < 10; i++) begin
      do_op(dv[i].s, dv[i].e, dv[i].m, dv[i].nan, dv[i].inf, sum, ov, uf, lat);
      checks++; if (sum !== dv[i].sum) begin failures++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, dv[i].sum); end
      checks++; if (ov !== dv[i].ov) begin failures++; $display("FAIL dir%0d_overflow: got %b expected %b", i, ov, dv[i].ov); end
      checks++; if (uf !== dv[i].uf) begin failures++; $display("FAIL dir%0d_underflow: got %b expected %b", i, uf, dv[i].uf); end
      checks++; if (lat != dv[i].lat) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, dv[i].lat); end
    end
  endtask

  task automatic test_stall;
    int n;
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h8000000; in_nan = 1'b0; in_inf = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_sum !== 32'h40000000) begin failures++; $display("FAIL stall_sum%0d: got %h expected 40000000", i, out_sum); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d: got %b expected 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready%0d: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_norm;
    logic [31:0] sum;
    logic        ov, uf;
    int          lat;
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0000010; in_nan = 1'b0; in_inf = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midnorm_busy: got ready=%b valid=%b expected ready=0 valid=0", in_ready, out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midnorm_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midnorm_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_sum !== 32'd0) begin failures++; $display("FAIL midnorm_out_sum: got %h expected 00000000", out_sum); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midnorm_discarded: got valid=%b expected 0", out_valid); end
    do_op(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, sum, ov, uf, lat);
    checks++; if (sum !== 32'h40000000) begin failures++; $display("FAIL post_reset_sum: got %h expected 40000000", sum); end
    checks++; if (lat != 3) begin failures++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_random;
    logic        s, nan, inf;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] sum, esum;
    logic        ov, uf, eov, euf;
    int          lat, elat;
    for (int i = 0; i < 200; i++) begin
      rand_operand(s, e, m, nan, inf);
      model(s, e, m, nan, inf, esum, eov, euf, elat);
      do_op(s, e, m, nan, inf, sum, ov, uf, lat);
      checks++; if (sum !== esum) begin failures++; $display("FAIL rnd%0d_sum: in s=%b e=%h m=%h nan=%b inf=%b got %h expected %h", i, s, e, m, nan, inf, sum, esum); end
      checks++; if (ov !== eov) begin failures++; $display("FAIL rnd%0d_overflow: got %b expected %b", i, ov, eov); end
      checks++; if (uf !== euf) begin failures++; $display("FAIL rnd%0d_underflow: got %b expected %b", i, uf, euf); end
      checks++; if (lat != elat) begin failures++; $display("FAIL rnd%0d_latency: e=%h m=%h got %0d expected %0d", i, e, m, lat, elat); end
    end
  endtask

  task automatic test_back_to_back;
    logic        s_v[8];
    logic [7:0]  e_v[8];
    logic [27:0] m_v[8];
    logic        nan_v[8];
    logic        inf_v[8];
    logic [31:0] exp_sum[$];
    logic [31:0] es;
    logic        eo, eu;
    int          el;
    int          idx, got, cyc;
    logic        pend;
    for (int i = 0; i < 8; i++) rand_operand(s_v[i], e_v[i], m_v[i], nan_v[i], inf_v[i]);
    idx = 0; got = 0; cyc = 0; pend = 1'b0;
    out_ready = 1'b1;
    in_sign = s_v[0]; in_exp = e_v[0]; in_mant = m_v[0]; in_nan = nan_v[0]; in_inf = inf_v[0];
    in_valid = 1'b1;
    while (got < 8 && cyc < 1000) begin
      if (in_valid && in_ready) begin
        model(s_v[idx], e_v[idx], m_v[idx], nan_v[idx], inf_v[idx], es, eo, eu, el);
        exp_sum.push_back(es);
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 8) begin
          in_sign = s_v[idx]; in_exp = e_v[idx]; in_mant = m_v[idx]; in_nan = nan_v[idx]; in_inf = inf_v[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      checks++; if (in_ready === 1'b1 && out_valid === 1'b1) begin failures++; $display("FAIL b2b_overlap: got ready=1 valid=1 expected not both"); end
      if (out_valid === 1'b1) begin
        if (exp_sum.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_extra: got output %h expected none", out_sum);
        end else begin
          es = exp_sum.pop_front();
          checks++; if (out_sum !== es) begin failures++; $display("FAIL b2b%0d_sum: got %h expected %h", got, out_sum, es); end
        end
        got++;
      end
    end
    checks++; if (got != 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", got); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = 8'd0;
    in_mant = 28'd0;
    in_nan = 1'b0;
    in_inf = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_directed;
    test_stall;
    test_reset_mid_norm;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have parameter MAX_NORM_CYC, default 27, the maximum number of NORM cycles before a forced exit to ROUND.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream adder result valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an input.
REQ-006 SHALL have port in_sign, input, 1, result sign.
REQ-007 SHALL have port in_exp, input, 8, biased exponent aligned to in_mant[26].
REQ-008 SHALL have port in_mant, input, 28, layout [27] carry, [26:3] significand, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port in_nan, input, 1, force quiet NaN.
REQ-010 SHALL have port in_inf, input, 1, force signed infinity.
REQ-011 SHALL have port out_valid, output, 1, out_sum valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_sum, output, 32, IEEE-754 single result.
REQ-014 SHALL have port out_overflow, output, 1, result rounded to infinity.
REQ-015 SHALL have port out_underflow, output, 1, result flushed or subnormal.

Function
REQ-016 SHALL use FSM states IDLE, NORM, ROUND, HOLD; in_ready=1 only in IDLE.
REQ-017 SHALL, on in_valid&&in_ready, capture all inputs and go to NORM; on in_nan/in_inf/zero mantissa it SHALL go directly to HOLD instead.
REQ-018 SHALL output 32'h7FC00000 for in_nan (priority over in_inf), {in_sign,8'hFF,23'b0} for in_inf, and {in_sign,31'b0} for in_mant==0.
REQ-019 SHALL, in NORM with mant[27]=1, shift right by 1 with bit0 |= shifted-out bit, increment exp, and go to ROUND, all in one cycle.
REQ-020 SHALL, in NORM with mant[27:26]==0 and exp>1, shift left by 1 and decrement exp, once per cycle.
REQ-021 SHALL exit NORM to ROUND when mant[26]=1, or exp==1, or MAX_NORM_CYC cycles have elapsed.
REQ-022 SHALL, in ROUND, apply round-to-nearest-even: increment the significand iff G&&(R||S||LSB).
REQ-023 SHALL, on rounding carry-out, set significand 24'h800000 and increment exp.
REQ-024 SHALL, for final exp>=255, output {sign,8'hFF,23'b0} with out_overflow=1.
REQ-025 SHALL have latency of 3 cycles from accept to out_valid for an already-normalized input, plus 1 cycle per extra left shift.
REQ-026 SHALL hold out_valid and out_sum stable in HOLD until out_ready; on out_valid&&out_ready it SHALL return to IDLE (no same-cycle re-accept).

Reset
REQ-027 SHALL, on reset (including mid-operation), set state IDLE, out_valid=0, out_sum=0, out_overflow=0, out_underflow=0, and discard any captured operand.
REQ-028 SHALL assert in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with FP_NORM_SUBNORMAL_EN defined, emit a subnormal when the NORM exit has exp==1 and mant[26]==0: exponent field 0, fraction = rounded mant[25:3], out_underflow=1.
REQ-030 SHALL, without FP_NORM_SUBNORMAL_EN, flush that case to {sign,31'b0} with out_underflow=1.

Structure
REQ-031 SHALL take FP32 field widths, EXP_BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000 and the state enum from shared package fp_pkg.
REQ-032 SHALL implement RNE increment/carry logic in combinational sub-module fp_rne_round.

Verification
REQ-033 SHALL cover: exp=127, mant=28'h8000000 -> out_sum 32'h40000000 with latency 3.
REQ-034 SHALL cover: exp=127, mant=28'h0800000 -> 32'h3E000000 after 3 left shifts (latency 5).
REQ-035 SHALL cover: exp=127, mant=28'h7FFFFFC (tie, LSB=1) -> 32'h40000000.
REQ-036 SHALL cover: exp=254, mant=28'h8000000 -> 32'h7F800000 with out_overflow=1.
REQ-037 SHALL cover: exp=1, mant=28'h2000000 -> 32'h00400000 with the macro, 32'h00000000 without it, out_underflow=1 in both cases.
REQ-038 SHALL cover: out_ready held low 5 cycles with out_sum stable and in_ready=0; reset pulsed in NORM -> out_valid=0 and in_ready=1 on the next cycle.
